// File: rtl/cache_mem_arbiter.sv
// ---------------------------------------------------------------------------
// cache_mem_arbiter
//
// Shares one single-ported word memory between the icache and dcache miss /
// writeback paths. One single-word transaction is granted at a time and
// sequenced through request, wait for mem_ready, and a one-cycle response.
// The dcache has priority. A starvation counter forces an icache grant after
// STARVE_LIMIT consecutive dcache grants taken while the icache was waiting.
// A watchdog raises a sticky mem_error if memory never answers within
// TIMEOUT cycles.
//
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   iREN, iaddr         icache read request / word address
//   iwait, iload        icache wait (low one cycle on completion) / read data
//   dREN, dWEN          dcache read / write request (both high => write)
//   daddr, dstore       dcache word address / write data
//   dwait, dload        dcache wait (low one cycle on completion) / read data
//   mem_req, mem_wen    memory access valid / write enable
//   mem_addr, mem_store memory address / write data
//   mem_load, mem_ready memory read data / one-cycle completion pulse
//   mem_error           sticky timeout flag
//
// Optional build macro ARB_STATS_EN adds igrant_cnt, dgrant_cnt and
// stall_cnt outputs. Arbitration is identical with or without it.
//
// state | meaning
// IDLE  | no access in flight, choose a grant
// IACC  | icache access issued, waiting for mem_ready
// DACC  | dcache access issued, waiting for mem_ready
// DONE  | completion cycle, granted wait driven low if still wanted
// ---------------------------------------------------------------------------
module cache_mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 64
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        mem_req,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_store,
    input  logic [31:0] mem_load,
    input  logic        mem_ready,
`ifdef ARB_STATS_EN
    output logic [31:0] igrant_cnt,
    output logic [31:0] dgrant_cnt,
    output logic [31:0] stall_cnt,
`endif
    output logic        mem_error
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, IACC, DACC, DONE} state_t;

    state_t        state;
    logic [SW-1:0] starve;
    logic [TW-1:0] tcnt;
    logic          dropped;   // granted requester let go at some point mid-access

    logic d_req;
    logic d_pick;
    logic i_pick;
    logic acc_req;

    always_comb begin
        d_req   = dREN | dWEN;
        d_pick  = d_req && !(iREN && (starve == SW'(STARVE_LIMIT)));
        i_pick  = !d_pick && iREN;
        acc_req = (state == IACC) ? iREN : d_req;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            starve    <= '0;
            tcnt      <= '0;
            dropped   <= 1'b0;
            mem_error <= 1'b0;
            mem_req   <= 1'b0;
            mem_wen   <= 1'b0;
            mem_addr  <= '0;
            mem_store <= '0;
            iwait     <= 1'b1;
            dwait     <= 1'b1;
            iload     <= '0;
            dload     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tcnt    <= '0;
                    dropped <= 1'b0;
                    if (d_pick) begin
                        mem_req   <= 1'b1;
                        mem_wen   <= dWEN;
                        mem_addr  <= daddr;
                        mem_store <= dWEN ? dstore : '0;
                        state     <= DACC;
                        if (!iREN)
                            starve <= '0;
                        else if (starve != SW'(STARVE_LIMIT))
                            starve <= starve + SW'(1);
                    end else if (i_pick) begin
                        mem_req   <= 1'b1;
                        mem_wen   <= 1'b0;
                        mem_addr  <= iaddr;
                        mem_store <= '0;
                        state     <= IACC;
                        starve    <= '0;
                    end
                end

                IACC, DACC: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        state   <= DONE;
                        // A requester that let go gets no data and no pulse.
                        if (!dropped && acc_req) begin
                            if (state == IACC) begin
                                iload <= mem_load;
                                iwait <= 1'b0;
                            end else begin
                                dload <= mem_load;
                                dwait <= 1'b0;
                            end
                        end
                    end else if (tcnt == TW'(TIMEOUT - 1)) begin
                        mem_error <= 1'b1;
                        mem_req   <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                        if (!acc_req)
                            dropped <= 1'b1;
                    end
                end

                DONE: begin
                    iwait <= 1'b1;
                    dwait <= 1'b1;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

`ifdef ARB_STATS_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            igrant_cnt <= '0;
            dgrant_cnt <= '0;
            stall_cnt  <= '0;
        end else begin
            if (state == IDLE && d_pick)
                dgrant_cnt <= dgrant_cnt + 32'd1;
            if (state == IDLE && i_pick)
                igrant_cnt <= igrant_cnt + 32'd1;
            if ((iREN && iwait) || (d_req && dwait))
                stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule
